// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset/lock sequencing with timeout retries, stability filter and lock-loss recovery.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 8
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic       lock_lost
);
  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAIL      = 3'd4;
  localparam logic [19:0] RST_LD = 20'(RST_CYCLES - 1);
  localparam logic [19:0] LT_LD  = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] ST_LD  = 20'(STABLE_CYCLES - 1);
  localparam logic [3:0]  MAX_R  = 4'(MAX_RETRIES);

  logic        s1, lk;
  logic [2:0]  state, ns;
  logic [19:0] cnt, cnt_n;
  logic [3:0]  rc_n, rc_inc;
  logic        ll_n;

  always_comb begin
    rc_inc = (retry_count == 4'hf) ? 4'hf : retry_count + 4'd1;
    ns     = state;
    cnt_n  = (cnt != 20'd0) ? cnt - 20'd1 : cnt;
    rc_n   = retry_count;
    ll_n   = lock_lost;
    if (restart) begin
      ns    = S_PLL_RST;
      cnt_n = RST_LD;
      rc_n  = 4'd0;
      ll_n  = 1'b0;
    end else begin
      case (state)
        S_PLL_RST: if (cnt == 20'd0) begin
          ns    = S_WAIT_LOCK;
          cnt_n = LT_LD;
        end
        // lock is checked first so a lock on the final timeout cycle is not counted as a retry
        S_WAIT_LOCK: if (lk) begin
          ns    = S_STABLE;
          cnt_n = ST_LD;
        end else if (cnt == 20'd0) begin
          rc_n  = rc_inc;
          ns    = (rc_inc >= MAX_R) ? S_FAIL : S_PLL_RST;
          cnt_n = RST_LD;
        end
        S_STABLE: if (!lk) begin
          ns    = S_PLL_RST;
          cnt_n = RST_LD;
        end else if (cnt == 20'd0) begin
          ns   = S_RUN;
          rc_n = 4'd0;
        end
        S_RUN: begin
          cnt_n = cnt;
          if (!lk) begin
            ns    = S_PLL_RST;
            cnt_n = RST_LD;
            ll_n  = 1'b1;
          end
        end
        S_FAIL: cnt_n = cnt;
        default: begin
          ns    = S_PLL_RST;
          cnt_n = RST_LD;
        end
      endcase
    end
  end

  // outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      s1          <= 1'b0;
      lk          <= 1'b0;
      state       <= S_PLL_RST;
      cnt         <= RST_LD;
      retry_count <= 4'd0;
      lock_lost   <= 1'b0;
      pll_rst     <= 1'b1;
      core_rst    <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      s1          <= pll_locked;
      lk          <= s1;
      state       <= ns;
      cnt         <= cnt_n;
      retry_count <= rc_n;
      lock_lost   <= ll_n;
      pll_rst     <= (ns == S_PLL_RST) || (ns == S_FAIL);
      core_rst    <= ns != S_RUN;
      ready       <= ns == S_RUN;
      fail        <= ns == S_FAIL;
    end
  end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed scenario bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;
  logic       refclk = 1'b0;
  logic       rst, pll_locked, restart;
  logic       pll_rst, core_rst, ready, fail, lock_lost;
  logic [3:0] retry_count;
  int checks = 0;
  int failures = 0;

  pll_lock_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(10), .STABLE_CYCLES(5), .MAX_RETRIES(3)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .restart(restart),
    .pll_rst(pll_rst), .core_rst(core_rst), .ready(ready), .fail(fail),
    .retry_count(retry_count), .lock_lost(lock_lost)
  );

  always #5 refclk = ~refclk;

  // sel: 0 ready high, 1 core_rst high, 2 pll_rst low, 3 pll_rst high; n = negedges waited
  task automatic wait_for(input int sel, output int n);
    n = 0;
    forever begin
      @(negedge refclk);
      n++;
      if ((sel == 0 && ready) || (sel == 1 && core_rst) || (sel == 2 && !pll_rst) ||
          (sel == 3 && pll_rst) || n >= 200) break;
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge refclk);
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b1; restart = 1'b0;
    repeat (3) @(negedge refclk);
    checks++;
    if ({pll_rst, core_rst, ready, fail, retry_count, lock_lost} !== 9'b1_1_0_0_0000_0) begin
      failures++;
      $display("FAIL reset_values got=%b want=%b", {pll_rst, core_rst, ready, fail, retry_count, lock_lost}, 9'b110000000);
    end
  endtask

  task automatic test_release();
    int n = 0;
    pll_locked = 1'b0;
    rst = 1'b0;
    while (pll_rst && n < 50) begin
      n++;
      @(negedge refclk);
    end
    checks++;
    if (n !== 4) begin failures++; $display("FAIL pll_rst_width got=%0d want=4", n); end
  endtask

  task automatic test_normal();
    int n;
    test_release();
    repeat (2) @(negedge refclk);
    pll_locked = 1'b1;
    wait_for(0, n);
    checks++;
    if (n !== 8) begin failures++; $display("FAIL lock_to_ready got=%0d want=8", n); end
    checks++;
    if ({core_rst, pll_rst, fail, retry_count} !== 7'b0) begin
      failures++; $display("FAIL run_outputs got=%b want=0000000", {core_rst, pll_rst, fail, retry_count});
    end
  endtask

  task automatic test_lock_loss();
    int n;
    pll_locked = 1'b0;
    wait_for(1, n);
    checks++;
    if (n !== 3) begin failures++; $display("FAIL loss_latency got=%0d want=3", n); end
    checks++;
    if ({ready, lock_lost} !== 2'b01) begin failures++; $display("FAIL loss_flags got=%b want=01", {ready, lock_lost}); end
    pll_locked = 1'b1;
    wait_for(0, n);
    checks++;
    if (n !== 10) begin failures++; $display("FAIL relock_time got=%0d want=10", n); end
    checks++;
    if (lock_lost !== 1'b1) begin failures++; $display("FAIL lock_lost_sticky got=%b want=1", lock_lost); end
    pulse_restart();
    checks++;
    if ({lock_lost, pll_rst, core_rst, ready} !== 4'b0110) begin
      failures++; $display("FAIL restart_clear got=%b want=0110", {lock_lost, pll_rst, core_rst, ready});
    end
  endtask

  task automatic test_timeout();
    int n;
    pll_locked = 1'b0;
    pulse_restart();
    for (int k = 1; k <= 3; k++) begin
      n = 0;
      do begin @(negedge refclk); n++; end while (retry_count == 4'(k - 1) && n < 100);
      checks++;
      if (n !== 14) begin failures++; $display("FAIL attempt%0d_time got=%0d want=14", k, n); end
      checks++;
      if (retry_count !== 4'(k)) begin failures++; $display("FAIL retry_count%0d got=%0d want=%0d", k, retry_count, k); end
      checks++;
      if ({fail, pll_rst} !== {k == 3, 1'b1}) begin
        failures++; $display("FAIL attempt%0d_fail got=%b want=%b", k, {fail, pll_rst}, {k == 3, 1'b1});
      end
    end
    repeat (20) @(negedge refclk);
    checks++;
    if ({fail, pll_rst, core_rst, ready, retry_count} !== 8'b1110_0011) begin
      failures++; $display("FAIL fail_hold got=%b want=11100011", {fail, pll_rst, core_rst, ready, retry_count});
    end
    pulse_restart();
    checks++;
    if ({fail, pll_rst, retry_count} !== 6'b01_0000) begin
      failures++; $display("FAIL fail_restart got=%b want=010000", {fail, pll_rst, retry_count});
    end
  endtask

  task automatic test_glitch();
    int n;
    logic seen = 1'b0;
    n = 0;
    do begin @(negedge refclk); n++; end while (retry_count == 4'd0 && n < 100);
    checks++;
    if (n !== 14 || retry_count !== 4'd1) begin
      failures++; $display("FAIL glitch_setup got=%0d/%0d want=14/1", n, retry_count);
    end
    wait_for(2, n);
    pll_locked = 1'b1;
    repeat (5) begin @(negedge refclk); seen |= ready; end
    pll_locked = 1'b0;
    @(negedge refclk); seen |= ready;
    pll_locked = 1'b1;
    wait_for(3, n);
    checks++;
    if (n !== 2) begin failures++; $display("FAIL glitch_return got=%0d want=2", n); end
    checks++;
    if ({seen, ready, fail, retry_count} !== 7'b000_0001) begin
      failures++; $display("FAIL glitch_state got=%b want=0000001", {seen, ready, fail, retry_count});
    end
    wait_for(0, n);
    checks++;
    if (n !== 10 || retry_count !== 4'd0) begin
      failures++; $display("FAIL glitch_recover got=%0d/%0d want=10/0", n, retry_count);
    end
  endtask

  task automatic test_boundary();
    int n;
    pll_locked = 1'b0;
    pulse_restart();
    wait_for(2, n);
    repeat (7) @(negedge refclk);
    pll_locked = 1'b1;
    repeat (3) @(negedge refclk);
    checks++;
    if ({pll_rst, core_rst, retry_count} !== 6'b01_0000) begin
      failures++; $display("FAIL boundary_lock got=%b want=010000", {pll_rst, core_rst, retry_count});
    end
    wait_for(0, n);
    checks++;
    if (n !== 5) begin failures++; $display("FAIL boundary_ready got=%0d want=5", n); end
  endtask

  task automatic test_async_reset();
    int n;
    pll_locked = 1'b0;
    wait_for(1, n);
    pll_locked = 1'b1;
    wait_for(2, n);
    @(negedge refclk);
    checks++;
    if ({pll_rst, core_rst, lock_lost} !== 3'b011) begin
      failures++; $display("FAIL stable_pre got=%b want=011", {pll_rst, core_rst, lock_lost});
    end
    @(posedge refclk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pll_rst, core_rst, ready, fail, retry_count, lock_lost} !== 9'b1_1_0_0_0000_0) begin
      failures++; $display("FAIL async_reset got=%b want=110000000", {pll_rst, core_rst, ready, fail, retry_count, lock_lost});
    end
    @(negedge refclk);
    test_release();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_lock_loss();
    test_timeout();
    test_glitch();
    test_boundary();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16: refclk cycles that pll_rst is held high per attempt; legal range 1..2^20-1.
REQ-002 Parameter LOCK_TIMEOUT, default 65535: refclk cycles to wait for lock before retrying; legal range 1..2^20-1.
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before release; legal range 1..2^20-1.
REQ-004 Parameter MAX_RETRIES, default 8: timed-out attempts allowed before FAIL; legal range 1..15.
REQ-005 refclk  input  1  sole clock; all sequential logic on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 pll_locked  input  1  PLL locked indication, asynchronous to refclk.
REQ-008 restart  input  1  synchronous single-cycle pulse; requests a full PLL re-initialisation.
REQ-009 pll_rst  output  1  reset to the PLL, active high.
REQ-010 core_rst  output  1  reset to logic clocked by the PLL outputs, active high.
REQ-011 ready  output  1  high only in RUN.
REQ-012 fail  output  1  high only in FAIL.
REQ-013 retry_count  output  4  number of timed-out attempts since the last successful entry to RUN, saturating at 15.
REQ-014 lock_lost  output  1  sticky; set on any lock loss in RUN; cleared only by rst or restart.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value (lk); latency 2 cycles.
REQ-016 The FSM SHALL have states PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL, and one shared 20-bit down-counter cnt.
REQ-017 PLL_RST: pll_rst=1, core_rst=1; cnt loaded RST_CYCLES-1 on entry; at cnt==0 -> WAIT_LOCK with cnt=LOCK_TIMEOUT-1; pll_rst is therefore high exactly RST_CYCLES cycles.
REQ-018 WAIT_LOCK: pll_rst=0, core_rst=1; if lk=1 -> STABLE with cnt=STABLE_CYCLES-1; else if cnt==0 -> timeout.
REQ-019 Timeout: retry_count increments (saturating); if the incremented value >= MAX_RETRIES -> FAIL, else -> PLL_RST.
REQ-020 Simultaneous lk=1 and cnt==0 in WAIT_LOCK: lock wins, no timeout counted.
REQ-021 STABLE: pll_rst=0, core_rst=1; lk=0 -> PLL_RST (no retry increment); lk=1 and cnt==0 -> RUN; so RUN is entered after exactly STABLE_CYCLES consecutive lk=1 cycles in STABLE.
REQ-022 RUN: pll_rst=0, core_rst=0, ready=1; on RUN entry retry_count clears to 0.
REQ-023 RUN with lk=0: next cycle state PLL_RST, core_rst=1, lock_lost=1; core_rst is registered, asserting one cycle after lk falls.
REQ-024 FAIL: pll_rst=1, core_rst=1, fail=1; remains until restart or rst.
REQ-025 restart=1 in any state SHALL, next cycle, enter PLL_RST, reload cnt, clear retry_count and lock_lost; restart has priority over all other transitions.
REQ-026 All outputs SHALL be registered; no combinational path from pll_locked or restart to any output.
REQ-027 cnt SHALL never wrap; it decrements only while nonzero in the timed states.

Reset
REQ-028 While rst=1: state=PLL_RST, cnt=RST_CYCLES-1, pll_rst=1, core_rst=1, ready=0, fail=0, retry_count=0, lock_lost=0, synchronizer flops=0.
REQ-029 After rst falls, PLL_RST SHALL hold pll_rst for exactly RST_CYCLES cycles before WAIT_LOCK.
REQ-030 rst asserted mid-operation (any state) SHALL immediately force the REQ-028 values regardless of clock.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=10, STABLE_CYCLES=5, MAX_RETRIES=3)
REQ-031 Normal: release rst, raise pll_locked 2 cycles after pll_rst falls -> pll_rst high 4 cycles; ready rises 2+5+1 cycles after pll_locked rises; retry_count=0.
REQ-032 Timeout/fail: pll_locked held 0 -> three attempts, retry_count 1,2,3, then fail=1, pll_rst=1; restart pulse -> PLL_RST, retry_count=0, fail=0.
REQ-033 Glitch in STABLE: pll_locked drops for 1 cycle after 3 stable cycles -> return to PLL_RST, retry_count unchanged, no ready pulse.
REQ-034 Lock loss in RUN: drop pll_locked -> core_rst=1 and ready=0 3 cycles later (2 sync + 1 register), lock_lost=1 sticky through relock to RUN.
REQ-035 Boundary: lk rises on the cycle cnt==0 in WAIT_LOCK -> STABLE, retry_count unchanged.
REQ-036 Async reset: assert rst mid-STABLE between clock edges -> all outputs at REQ-028 values before the next refclk edge.
